// File: rtl/conv_pe_5x5_seq.sv
// Sequential 5x5 convolution PE: serially loaded signed kernel,
// one window row multiply-accumulated per cycle, ReLU/saturated output.
module conv_pe_5x5_seq #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_wgt_clear,
  input  logic                    i_wgt_valid,
  input  logic signed [7:0]       i_wgt_data,
  output logic                    o_wgt_loaded,
  input  logic signed [ACC_W-1:0] i_bias,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_row_start,
  input  logic                    i_row_end,
  input  logic [199:0]            i_win,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic signed [ACC_W-1:0] o_acc,
  output logic [7:0]              o_pixel,
  output logic                    o_first,
  output logic                    o_last,
  output logic [4:0]              o_col
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t                  state;
  logic signed [7:0]       kern [25];
  logic [4:0]              idx;
  logic [2:0]              row;
  logic [199:0]            win_q;
  logic signed [ACC_W-1:0] acc;
  logic                    first_q;
  logic                    last_q;
  logic                    pend;

  logic                    wgt_we;
  logic                    accept;
  logic [4:0]              k_i;
  logic signed [8:0]       pix9;
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] row_sum;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              pix;

  assign wgt_we = reset_n && state == IDLE && !o_wgt_loaded
                  && i_wgt_valid && !i_wgt_clear;
  assign accept = i_valid && o_ready;

  // Kernel storage has no reset; contents are only trusted once loaded.
  always_ff @(posedge clk) begin
    if (wgt_we) kern[idx] <= i_wgt_data;
  end

  always_comb begin
    row_sum = '0;
    k_i     = '0;
    pix9    = '0;
    prod    = '0;
    for (int c = 0; c < 5; c++) begin
      k_i     = 5'(5 * int'(row) + c);
      pix9    = $signed({1'b0, win_q[{k_i, 3'b000} +: 8]});
      prod    = pix9 * kern[k_i];
      row_sum = row_sum + {{(ACC_W-17){prod[16]}}, prod};
    end
    sum     = acc + row_sum;
    shifted = sum >>> SHIFT;
    if (shifted[ACC_W-1])
      pix = 8'd0;
    else if (|shifted[ACC_W-2:8])
      pix = 8'hFF;
    else
      pix = shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      o_wgt_loaded <= 1'b0;
      idx          <= '0;
      row          <= '0;
      win_q        <= '0;
      acc          <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      pend         <= 1'b0;
      o_ready      <= 1'b0;
      o_out_valid  <= 1'b0;
      o_acc        <= '0;
      o_pixel      <= '0;
      o_first      <= 1'b0;
      o_last       <= 1'b0;
      o_col        <= '0;
    end else begin
      if (i_row_start) pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_wgt_clear) begin
            idx          <= '0;
            o_wgt_loaded <= 1'b0;
          end else if (wgt_we) begin
            if (idx == 5'd24) begin
              idx          <= '0;
              o_wgt_loaded <= 1'b1;
            end else begin
              idx <= idx + 5'd1;
            end
          end
          if (accept) begin
            win_q   <= i_win;
            acc     <= i_bias;
            first_q <= pend | i_row_start;
            last_q  <= i_row_end;
            pend    <= 1'b0;
            row     <= '0;
            o_ready <= 1'b0;
            state   <= MAC;
          end else begin
            o_ready <= !i_wgt_clear
                       && (o_wgt_loaded || (wgt_we && idx == 5'd24));
          end
        end
        MAC: begin
          acc <= sum;
          row <= row + 3'd1;
          if (row == 3'd4) begin
            state       <= OUT;
            o_out_valid <= 1'b1;
            o_acc       <= sum;
            o_pixel     <= pix;
            o_first     <= first_q;
            o_last      <= last_q;
            if (first_q)
              o_col <= '0;
            else if (o_col != 5'd31)
              o_col <= o_col + 5'd1;
          end
        end
        OUT: begin
          if (i_out_ready) begin
            state       <= IDLE;
            o_out_valid <= 1'b0;
            o_ready     <= o_wgt_loaded;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pe_5x5_seq.sv
// Directed bench for conv_pe_5x5_seq: kernel load, arithmetic corners,
// row tags with a downstream stall, and reset during accumulation.
module tb_conv_pe_5x5_seq;

  localparam int ACC_W = 24;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    i_wgt_clear = 1'b0;
  logic                    i_wgt_valid = 1'b0;
  logic signed [7:0]       i_wgt_data = '0;
  logic signed [ACC_W-1:0] i_bias = '0;
  logic                    i_valid = 1'b0;
  logic                    i_row_start = 1'b0;
  logic                    i_row_end = 1'b0;
  logic [199:0]            i_win = '0;
  logic                    i_out_ready = 1'b0;

  logic                    o_wgt_loaded, o_ready, o_out_valid;
  logic signed [ACC_W-1:0] o_acc;
  logic [7:0]              o_pixel;
  logic                    o_first, o_last;
  logic [4:0]              o_col;

  logic                    ld2, rdy2, ov2, f2, l2;
  logic signed [ACC_W-1:0] acc2;
  logic [7:0]              pix2;
  logic [4:0]              col2;

  int total = 0;
  int bad = 0;
  logic [7:0] kv [25];

  always #5 clk = ~clk;

  conv_pe_5x5_seq #(.ACC_W(ACC_W), .SHIFT(0)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_wgt_clear(i_wgt_clear), .i_wgt_valid(i_wgt_valid),
    .i_wgt_data(i_wgt_data), .o_wgt_loaded(o_wgt_loaded),
    .i_bias(i_bias), .i_valid(i_valid), .o_ready(o_ready),
    .i_row_start(i_row_start), .i_row_end(i_row_end), .i_win(i_win),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_acc(o_acc), .o_pixel(o_pixel), .o_first(o_first),
    .o_last(o_last), .o_col(o_col)
  );

  conv_pe_5x5_seq #(.ACC_W(ACC_W), .SHIFT(12)) u_dut12 (
    .clk(clk), .reset_n(reset_n),
    .i_wgt_clear(i_wgt_clear), .i_wgt_valid(i_wgt_valid),
    .i_wgt_data(i_wgt_data), .o_wgt_loaded(ld2),
    .i_bias(i_bias), .i_valid(i_valid), .o_ready(rdy2),
    .i_row_start(i_row_start), .i_row_end(i_row_end), .i_win(i_win),
    .o_out_valid(ov2), .i_out_ready(i_out_ready),
    .o_acc(acc2), .o_pixel(pix2), .o_first(f2),
    .o_last(l2), .o_col(col2)
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] fill(input logic [7:0] v);
    return {25{v}};
  endfunction

  task automatic load_k();
    i_wgt_clear = 1'b1;
    step();
    i_wgt_clear = 1'b0;
    for (int i = 0; i < 25; i++) begin
      i_wgt_valid = 1'b1;
      i_wgt_data  = kv[i];
      step();
    end
    i_wgt_valid = 1'b0;
    check("wgt_loaded", o_wgt_loaded, 1);
    check("ready_after_load", o_ready, 1);
  endtask

  task automatic send(input logic [199:0] w, input logic [ACC_W-1:0] b,
                      input logic re);
    int n;
    n = 0;
    while (!o_ready && n < 30) begin
      step();
      n++;
    end
    if (!o_ready) check("ready_timeout", 0, 1);
    i_valid   = 1'b1;
    i_win     = w;
    i_bias    = b;
    i_row_end = re;
    step();
    i_valid   = 1'b0;
    i_row_end = 1'b0;
    check("ready_low_after_accept", o_ready, 0);
    n = 0;
    while (!o_out_valid && n < 20) begin
      step();
      n++;
    end
    check("latency", n, 5);
  endtask

  task automatic finish_out();
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
    check("valid_drop", o_out_valid, 0);
    check("ready_back", o_ready, 1);
  endtask

  initial begin
    logic [199:0] w;
    int spur;

    step();
    step();
    check("rst_valid", o_out_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_loaded", o_wgt_loaded, 0);
    check("rst_acc", o_acc, 0);
    check("rst_col", o_col, 0);
    reset_n = 1'b1;
    step();

    // all-ones kernel and window
    for (int i = 0; i < 25; i++) kv[i] = 8'd1;
    load_k();
    send(fill(8'd1), 0, 1'b0);
    check("ones_acc", $signed(o_acc), 25);
    check("ones_pix", o_pixel, 25);
    i_wgt_valid = 1'b1;
    i_wgt_data  = 8'sd0;
    step();
    i_wgt_valid = 1'b0;
    finish_out();
    send(fill(8'd1), 0, 1'b0);
    check("ones_again_acc", $signed(o_acc), 25);
    finish_out();

    // centre tap only
    for (int i = 0; i < 25; i++) kv[i] = 8'd0;
    kv[12] = 8'd1;
    load_k();
    w = fill(8'd255);
    w[103:96] = 8'd200;
    send(w, 3, 1'b0);
    check("center_acc", $signed(o_acc), 203);
    check("center_pix", o_pixel, 203);
    finish_out();

    // negative result clamps to zero
    for (int i = 0; i < 25; i++) kv[i] = 8'hFF;
    load_k();
    send(fill(8'd10), 0, 1'b0);
    check("neg_acc", $signed(o_acc), -250);
    check("neg_pix", o_pixel, 0);
    finish_out();

    // largest positive products
    for (int i = 0; i < 25; i++) kv[i] = 8'd127;
    load_k();
    send(fill(8'd255), 0, 1'b0);
    check("max_acc", $signed(o_acc), 809625);
    check("max_pix", o_pixel, 255);
    check("max_pix_shift12", pix2, 197);
    finish_out();

    // one row of 28 windows with a stall on window 3
    for (int i = 0; i < 25; i++) kv[i] = 8'd1;
    load_k();
    i_row_start = 1'b1;
    step();
    i_row_start = 1'b0;
    for (int i = 0; i < 28; i++) begin
      send(fill(8'(i)), 0, i == 27);
      check("row_acc", $signed(o_acc), 25 * i);
      check("row_pix", o_pixel, (25 * i > 255) ? 255 : 25 * i);
      check("row_first", o_first, i == 0);
      check("row_last", o_last, i == 27);
      check("row_col", o_col, i);
      if (i == 3) begin
        for (int s = 0; s < 10; s++) begin
          i_valid = 1'b1;
          i_win   = fill(8'd99);
          step();
          check("stall_valid", o_out_valid, 1);
          check("stall_acc", $signed(o_acc), 75);
          check("stall_col", o_col, 3);
          check("stall_ready", o_ready, 0);
        end
        i_valid = 1'b0;
      end
      finish_out();
    end

    // reset while accumulating row 2
    send(fill(8'd1), 0, 1'b0);
    finish_out();
    i_valid = 1'b1;
    i_win   = fill(8'd4);
    step();
    i_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst_valid", o_out_valid, 0);
    check("mid_rst_loaded", o_wgt_loaded, 0);
    check("mid_rst_ready", o_ready, 0);
    check("mid_rst_acc", o_acc, 0);
    check("mid_rst_pix", o_pixel, 0);
    check("mid_rst_col", o_col, 0);
    check("mid_rst_last", o_last, 0);
    spur = 0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (o_out_valid) spur++;
    end
    check("no_spurious_valid", spur, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_pe_5x5_seq.md
Name: conv_pe_5x5_seq

Overview:
- Sequential 5x5 convolution processing element; the consumer end of the line-buffer controller's window interface.
- Accepts one 25-pixel window per valid/ready handshake and multiply-accumulates it against a serially loaded 5x5 signed kernel, one window row per cycle.
- Emits a raw accumulator value and a ReLU/saturated 8-bit pixel with row-boundary tags to the downstream feature-map writer.

Parameters:
- ACC_W, 24, accumulator/bias width (signed).
- SHIFT, 0, arithmetic right shift applied before ReLU/saturation of o_pixel (0..ACC_W-1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- i_wgt_clear  in  1  pulse: discard kernel, restart load at index 0.
- i_wgt_valid  in  1  kernel write strobe.
- i_wgt_data  in  8  signed weight, row-major order k[0][0]..k[4][4].
- o_wgt_loaded  out  1  all 25 weights present.
- i_bias  in  ACC_W  signed bias, sampled on window accept.
- i_valid  in  1  window valid.
- o_ready  out  1  PE can accept a window.
- i_row_start  in  1  pulse: next accepted window is first of an output row.
- i_row_end  in  1  window on the accept cycle is last of its row.
- i_win  in  200  25 unsigned pixels; bits [8*(5r+c)+7 : 8*(5r+c)] = window r,c.
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  downstream accepts result.
- o_acc  out  ACC_W  signed raw sum.
- o_pixel  out  8  ReLU + saturated pixel.
- o_first / o_last  out  1 each  row tags of the current result.
- o_col  out  5  column index of the result within its row.

Behaviour:
- Reset: state IDLE; o_wgt_loaded=0; weight index=0; o_ready=0; o_out_valid=0; o_acc=0; o_pixel=0; o_first=0; o_last=0; o_col=0; pending-first flag=0. Kernel contents are don't-care.
- Weight load:
  - Accepted only when state=IDLE and o_wgt_loaded=0.
  - Each strobe writes the weight at the index, then increments the index.
  - The write at index 24 sets o_wgt_loaded=1 and index=0.
  - Strobes while loaded or busy are ignored.
  - i_wgt_clear wins over a same-cycle i_wgt_valid; it is honoured only in IDLE and ignored otherwise.
- o_ready = (state==IDLE) && o_wgt_loaded. Registered, so it is low on the cycle after an accept.
- States:
  - IDLE: on i_valid&&o_ready (edge E), latch i_win, acc<=i_bias, latch first=pending_first, latch last=i_row_end, clear pending_first, row counter<=0, go to MAC.
  - MAC: each cycle, acc += sum over c of zext(pix[r][c]) * sext(k[r][c]), r = row counter. After r=4 (edge E+5), go to OUT.
  - OUT: o_out_valid=1 from cycle after E+5; o_acc, o_pixel and the tags are stable until i_out_ready. On the handshake edge, go to IDLE; o_out_valid=0 and o_ready=1 next cycle.
- Timing: latency from accept edge to o_out_valid visible is 5 cycles. Minimum window period is 7 cycles.
- Arithmetic:
  - Pixel is zero-extended to 9-bit signed; product is 17-bit signed; row partial sum is sign-extended to ACC_W.
  - o_pixel = clamp(acc >>> SHIFT, 0, 255).
- Row tags:
  - i_row_start sets pending_first in any state, including while busy, and is sticky until the next accept.
  - If i_row_start coincides with an accept, that window is first.
  - i_row_end counts only on the accept cycle.
  - o_col: 0 for a first-tagged result, otherwise previous o_col+1, saturating at 31. Updated when the result is presented.
- i_valid while not ready: ignored; no latching.
- Reset mid-MAC or mid-OUT: returns to the reset state immediately, the result is dropped, and the kernel must be reloaded.

Test Plan:
- Load all weights 1, bias 0, SHIFT 0, all pixels 1, accept -> o_out_valid exactly 5 cycles after accept edge; o_acc=25; o_pixel=25.
- Kernel center k[2][2]=1, others 0; window center 200, others 255; bias 3 -> o_acc=203; o_pixel=203.
- All weights -1, pixels 10, bias 0 -> o_acc=-250; o_pixel=0.
- All weights 127, pixels 255 -> o_acc=809625; o_pixel=255. With SHIFT=12 -> o_pixel=197.
- i_row_start pulse, then 28 windows with i_row_end on the 28th; i_out_ready held low 10 cycles on window 3 -> o_first only on result 0, o_last only on result 27, o_col 0..27. While stalled: outputs stable, o_ready low, i_valid ignored.
- Covered alongside: i_wgt_valid while busy is ignored; reset asserted at MAC row 2 clears all outputs and o_wgt_loaded; no spurious o_out_valid.
